// File: rtl/sipo_deserializer_if.sv
// Parallel/serial bus bundle for sipo_deserializer.
// The master drives the framed serial stream; the slave (the deserializer) returns the word.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             si;
    logic             si_valid;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             par_err;
    logic             busy;
    logic [7:0]       frame_cnt;

    modport master (
        output start, si, si_valid,
        input  po, po_valid, par_err, busy, frame_cnt
    );

    modport slave (
        input  start, si, si_valid,
        output po, po_valid, par_err, busy, frame_cnt
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: start strobe, WIDTH qualified data bits,
// optional even-parity bit; registered word, one-cycle valid pulse and parity flag.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    sipo_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_par;
    logic [WIDTH-1:0] r_po;
    logic             r_po_valid;
    logic             r_par_err;
    logic             r_busy;
    logic [7:0]       r_frame_cnt;
    logic [WIDTH-1:0] w_shift;

    always_comb begin
        w_shift = r_shreg;
        if (MSB_FIRST != 0)
            w_shift = {r_shreg[WIDTH-2:0], bus.si};
        else
            w_shift = {bus.si, r_shreg[WIDTH-1:1]};
    end

    // r_par accumulates every captured bit, so in DONE it already equals data^parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_par       <= 1'b0;
            r_po        <= '0;
            r_po_valid  <= 1'b0;
            r_par_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_po_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                        r_par   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.si_valid) begin
                        r_shreg <= w_shift;
                        r_par   <= r_par ^ bus.si;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH - 1))
                            r_state <= (PARITY_EN != 0) ? PARITY : DONE;
                    end
                end
                PARITY: begin
                    if (bus.si_valid) begin
                        r_par   <= r_par ^ bus.si;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_po        <= r_shreg;
                    r_par_err   <= (PARITY_EN != 0) && r_par;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    r_po_valid  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.po        = r_po;
    assign bus.po_valid  = r_po_valid;
    assign bus.par_err   = r_par_err;
    assign bus.busy      = r_busy;
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: default build (a) and LSB-first, no-parity build (b).
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nchecks = 0;
    int   nerrs   = 0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(4)) a_if();
    sipo_deserializer_if #(.WIDTH(4)) b_if();

    sipo_deserializer #(.WIDTH(4), .PARITY_EN(1), .MSB_FIRST(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    sipo_deserializer #(.WIDTH(4), .PARITY_EN(0), .MSB_FIRST(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #4 rst = 1'b0;
        tick();
    endtask

    // Full frame on a: start edge, 4 data bits (w[3] first), parity, DONE edge.
    task automatic send_a(input logic [3:0] w, input logic p);
        a_if.start = 1'b1;
        tick();
        a_if.start    = 1'b0;
        a_if.si_valid = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            a_if.si = w[i];
            tick();
        end
        a_if.si = p;
        tick();
        a_if.si_valid = 1'b0;
        a_if.si       = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] w;
        logic       p;
        logic [3:0] bits;

        a_if.start = 1'b0; a_if.si = 1'b0; a_if.si_valid = 1'b0;
        b_if.start = 1'b0; b_if.si = 1'b0; b_if.si_valid = 1'b0;

        // Reset state
        do_reset();
        chk("rst_po",        32'(a_if.po),        32'h0);
        chk("rst_po_valid",  32'(a_if.po_valid),  32'h0);
        chk("rst_par_err",   32'(a_if.par_err),   32'h0);
        chk("rst_busy",      32'(a_if.busy),      32'h0);
        chk("rst_frame_cnt", 32'(a_if.frame_cnt), 32'h0);

        // Basic frame 1,0,1,0 parity 0, with edge-by-edge timing
        a_if.start = 1'b1;
        tick();                              // E0
        a_if.start = 1'b0;
        chk("basic_busy_E0", 32'(a_if.busy), 32'h1);
        a_if.si_valid = 1'b1;
        bits = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            a_if.si = bits[i];
            tick();                          // E1..E4
        end
        a_if.si = 1'b0;
        tick();                              // E5
        a_if.si_valid = 1'b0;
        chk("basic_pv_E5",   32'(a_if.po_valid), 32'h0);
        chk("basic_busy_E5", 32'(a_if.busy),     32'h1);
        tick();                              // E6
        chk("basic_pv_E6",   32'(a_if.po_valid),  32'h1);
        chk("basic_po",      32'(a_if.po),        32'ha);
        chk("basic_par_err", 32'(a_if.par_err),   32'h0);
        chk("basic_cnt",     32'(a_if.frame_cnt), 32'h1);
        chk("basic_busy_E6", 32'(a_if.busy),      32'h0);
        tick();                              // E7
        chk("basic_pv_E7",   32'(a_if.po_valid),  32'h0);
        chk("basic_po_hold", 32'(a_if.po),        32'ha);

        // Parity error, then a good frame back-to-back
        do_reset();
        send_a(4'b1110, 1'b0);
        chk("perr_po",  32'(a_if.po),      32'he);
        chk("perr_err", 32'(a_if.par_err), 32'h1);
        send_a(4'b0110, 1'b0);
        chk("pok_pv",  32'(a_if.po_valid),  32'h1);
        chk("pok_po",  32'(a_if.po),        32'h6);
        chk("pok_err", 32'(a_if.par_err),   32'h0);
        chk("pok_cnt", 32'(a_if.frame_cnt), 32'h2);

        // Stall for 3 cycles after bit 2 with a mid-frame start pulse
        do_reset();
        a_if.start = 1'b1;
        tick();                              // E0
        a_if.start    = 1'b0;
        a_if.si_valid = 1'b1;
        a_if.si = 1'b1; tick();              // E1
        a_if.si = 1'b0; tick();              // E2
        a_if.si_valid = 1'b0;
        a_if.si = 1'b1;
        tick();                              // E3
        a_if.start = 1'b1;
        tick();                              // E4
        a_if.start = 1'b0;
        tick();                              // E5
        a_if.si_valid = 1'b1;
        a_if.si = 1'b1; tick();              // E6
        a_if.si = 1'b0; tick();              // E7
        a_if.si = 1'b0; tick();              // E8
        a_if.si_valid = 1'b0;
        chk("stall_pv_E8",   32'(a_if.po_valid), 32'h0);
        chk("stall_busy_E8", 32'(a_if.busy),     32'h1);
        tick();                              // E9
        chk("stall_pv_E9", 32'(a_if.po_valid),  32'h1);
        chk("stall_po",    32'(a_if.po),        32'ha);
        chk("stall_cnt",   32'(a_if.frame_cnt), 32'h1);
        tick();
        chk("stall_no_restart", 32'(a_if.busy), 32'h0);

        // LSB-first, no parity on b: 1,0,0,0 then 1,1,0,1
        do_reset();
        b_if.start = 1'b1;
        tick();                              // E0
        b_if.start    = 1'b0;
        b_if.si_valid = 1'b1;
        bits = 4'b1000;
        for (int i = 3; i >= 0; i--) begin
            b_if.si = bits[i];
            tick();                          // E1..E4
        end
        b_if.si_valid = 1'b0;
        chk("np_pv_E4", 32'(b_if.po_valid), 32'h0);
        tick();                              // E5
        chk("np_pv_E5",   32'(b_if.po_valid), 32'h1);
        chk("np_po",      32'(b_if.po),       32'h1);
        chk("np_par_err", 32'(b_if.par_err),  32'h0);
        b_if.start = 1'b1;
        tick();
        b_if.start    = 1'b0;
        b_if.si_valid = 1'b1;
        bits = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            b_if.si = bits[i];
            tick();
        end
        b_if.si_valid = 1'b0;
        tick();
        chk("np2_po",      32'(b_if.po),        32'hb);
        chk("np2_par_err", 32'(b_if.par_err),   32'h0);
        chk("np2_cnt",     32'(b_if.frame_cnt), 32'h2);

        // Asynchronous reset mid-frame
        do_reset();
        send_a(4'b1110, 1'b0);
        a_if.start = 1'b1;
        tick();
        a_if.start    = 1'b0;
        a_if.si_valid = 1'b1;
        a_if.si = 1'b1; tick();
        a_if.si = 1'b1; tick();
        a_if.si_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_po",       32'(a_if.po),        32'h0);
        chk("mrst_par_err",  32'(a_if.par_err),   32'h0);
        chk("mrst_busy",     32'(a_if.busy),      32'h0);
        chk("mrst_cnt",      32'(a_if.frame_cnt), 32'h0);
        chk("mrst_po_valid", 32'(a_if.po_valid),  32'h0);
        #3 rst = 1'b0;
        tick();
        send_a(4'b0101, 1'b0);
        chk("mrst_new_pv",  32'(a_if.po_valid),  32'h1);
        chk("mrst_new_po",  32'(a_if.po),        32'h5);
        chk("mrst_new_cnt", 32'(a_if.frame_cnt), 32'h1);

        // 256 back-to-back frames, 7-cycle period, counter wrap
        do_reset();
        for (int k = 0; k < 256; k++) begin
            w = 4'($urandom_range(0, 15));
            p = 1'($urandom_range(0, 1));
            send_a(w, p);
            chk("b2b_pv",  32'(a_if.po_valid),  32'h1);
            chk("b2b_po",  32'(a_if.po),        32'(w));
            chk("b2b_err", 32'(a_if.par_err),   32'(^{w, p}));
            chk("b2b_cnt", 32'(a_if.frame_cnt), 32'((k + 1) % 256));
        end
        chk("wrap_cnt", 32'(a_if.frame_cnt), 32'h0);
        tick();
        chk("b2b_pv_low", 32'(a_if.po_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end
endmodule
